pipeline_credit_sink: RTL and testbench

- Receive-side endpoint for a fixed-latency, non-stallable data pipeline.
- The upstream issuer may only launch a beat while it holds a credit.
- Beats arriving at the pipeline output are caught in a DEPTH-entry circular FIFO and presented downstream with valid/ready.
- A credit returns only when a beat leaves downstream, so beats in flight through the pipeline are never dropped, regardless of downstream stalls.

---
 rtl/pipeline_credit_sink.sv | 148 ++++++++++++++
 tb/tb_pipeline_credit_sink.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_credit_sink.sv
// Generic circular FIFO used by the credit sink.
// Latency: a write is readable the cycle after it is accepted; no fall-through path.
// Backpressure: wr_rdy drops only when full with no read in the same cycle.
//
// Ports: clk/rst_n; wr_vld/wr_dat/wr_rdy write side; rd_vld/rd_rdy/rd_dat read side;
//        count = entries currently stored.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_rdy,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_nxt;
  logic          wr_fire;
  logic          rd_fire;
  logic          full;

  // Pointers wrap explicitly so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign rd_vld  = (count != '0);
  assign rd_fire = rd_vld && rd_rdy;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_rdy  = !full || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (wr_fire && !rd_fire) begin
      count_nxt = count + CW'(1);
    end else if (!wr_fire && rd_fire) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_fire) wptr <= ptr_inc(wptr);
      if (rd_fire) rptr <= ptr_inc(rptr);
      count <= count_nxt;
    end
  end

  // Storage carries no reset; rd_dat is only meaningful while rd_vld is high.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr] <= wr_dat;
  end

endmodule

// Receive endpoint of a fixed-latency non-stallable pipeline, credit-gating the issuer.
// Latency: beat on pipe_valid in cycle t is presented on out_valid/out_data in cycle t+1.
// Backpressure: out_ready stalls only the FIFO; credits return on pop so pipe_valid never stalls.
//
// Ports: issue_valid/issue_ready  upstream launch handshake (ready = credit available)
//        pipe_valid/pipe_data     beat leaving the external pipeline (never gated)
//        out_valid/out_ready/out_data  downstream valid/ready stream (FIFO head)
//        occupancy/credits        live counters; overflow_err sticky drop indicator
module pipeline_credit_sink #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          pipe_valid,
  input  logic [DW-1:0] pipe_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] occupancy,
  output logic [CW-1:0] credits,
  output logic          overflow_err
);

  logic          issue_fire;
  logic          pop;
  logic          fifo_wr_rdy;
  logic [CW-1:0] credits_nxt;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (pipe_valid),
    .wr_dat (pipe_data),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (out_data),
    .count  (occupancy)
  );

  assign issue_ready = (credits != '0);
  assign issue_fire  = issue_valid && issue_ready;
  assign pop         = out_valid && out_ready;

  // Credit returns on pop. The cap at DEPTH only matters if the issuer has
  // pushed beats it held no credit for; a legal issuer never reaches it.
  always_comb begin
    credits_nxt = credits;
    if (issue_fire && !pop) begin
      credits_nxt = credits - CW'(1);
    end else if (!issue_fire && pop && (credits != CW'(DEPTH))) begin
      credits_nxt = credits + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits      <= CW'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      credits <= credits_nxt;
      // A beat the FIFO cannot take is lost; remember it until reset.
      if (pipe_valid && !fifo_wr_rdy) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_credit_sink.sv
module tb_pipeline_credit_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] credits;
  logic          overflow_err;

  pipeline_credit_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .pipe_valid   (pipe_valid),
    .pipe_data    (pipe_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .credits      (credits),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a queue plus a credit count ----------------
  int            m_cred = DEPTH;
  logic [DW-1:0] mq[$];
  bit            m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cred = DEPTH;
      mq.delete();
      m_ovf  = 1'b0;
    end else begin
      int f;
      int p;
      f = (issue_valid && m_cred != 0) ? 1 : 0;
      p = (out_ready && mq.size() != 0) ? 1 : 0;
      if (p == 1) void'(mq.pop_front());
      if (pipe_valid) begin
        if (mq.size() < DEPTH) mq.push_back(pipe_data);
        else m_ovf = 1'b1;
      end
      m_cred = m_cred - f + p;
      if (m_cred > DEPTH) m_cred = DEPTH;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic [DW-1:0] got[$];
  bit            dead_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_issue_ready", issue_ready, (m_cred != 0));
      chk("cyc_credits", credits, m_cred);
      chk("cyc_occupancy", occupancy, mq.size());
      chk("cyc_out_valid", out_valid, (mq.size() != 0));
      chk("cyc_overflow", overflow_err, m_ovf);
      if (mq.size() != 0) chk("cyc_out_data", out_data, mq[0]);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_data == 32'h0000_DEAD) dead_seen = 1'b1;
      end
    end
  end

  // ---------------- issuer + 2-cycle external pipeline ----------------
  logic          dl_v [2];
  logic [DW-1:0] dl_d [2];
  logic [DW-1:0] data_ctr;
  int            fire_cnt;

  task automatic clear_pipe();
    for (int i = 0; i < 2; i++) begin
      dl_v[i] = 1'b0;
      dl_d[i] = '0;
    end
  endtask

  // One clock: drive inputs, sample the handshake, advance the pipeline.
  // inj forces an extra beat onto pipe_valid (models an issuer breaking the credit rule).
  task automatic cycle(input logic iv, input logic ordy,
                       input logic inj = 1'b0, input logic [DW-1:0] inj_dat = '0);
    logic fire;
    issue_valid = iv;
    out_ready   = ordy;
    pipe_valid  = dl_v[1] | inj;
    pipe_data   = inj ? inj_dat : dl_d[1];
    @(negedge clk);
    fire = iv && issue_ready;
    @(posedge clk);
    #1;
    dl_v[1] = dl_v[0];
    dl_d[1] = dl_d[0];
    dl_v[0] = fire;
    dl_d[0] = data_ctr;
    if (fire) begin
      data_ctr = data_ctr + 1;
      fire_cnt++;
    end
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, "_credits"}, credits, DEPTH);
    chk({tag, "_issue_ready"}, issue_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_overflow"}, overflow_err, 1'b0);
  endtask

  initial begin
    int bad;
    rst_n       = 1'b1;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    pipe_valid  = 1'b0;
    pipe_data   = '0;
    data_ctr    = '0;
    fire_cnt    = 0;
    clear_pipe();

    // ---- reset then idle ----
    #1 rst_n = 1'b0;
    #1 expect_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0);
    expect_reset_outputs("idle");

    // ---- single beat ----
    data_ctr = 32'hA5A5_0001;
    cycle(1'b1, 1'b1);
    chk("single_credits_after_fire", credits, 3);
    cycle(1'b0, 1'b1);
    chk("single_not_yet_valid", out_valid, 1'b0);
    cycle(1'b0, 1'b1);                      // pipe_valid this cycle
    chk("single_valid_next_cycle", out_valid, 1'b1);
    chk("single_out_data", out_data, 32'hA5A5_0001);
    cycle(1'b0, 1'b1);                      // pop
    chk("single_credits_back", credits, 4);
    chk("single_empty", out_valid, 1'b0);

    // ---- downstream stall, fill, then drain in order ----
    got.delete();
    data_ctr = 1;
    fire_cnt = 0;
    repeat (8) cycle(1'b1, 1'b0);
    chk("stall_fire_count", fire_cnt, 4);
    chk("stall_issue_ready", issue_ready, 1'b0);
    chk("stall_occupancy", occupancy, 4);
    chk("stall_credits", credits, 0);
    repeat (6) cycle(1'b0, 1'b1);
    chk("stall_drain_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stall_drain_order", got[i], i + 1);
    chk("stall_credits_back", credits, 4);

    // ---- streaming: one fire and one pop per cycle in steady state ----
    got.delete();
    data_ctr = 100;
    fire_cnt = 0;
    repeat (110) cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1);
    chk("stream_no_stall_fires", fire_cnt, 110);
    chk("stream_delivered", got.size(), 110);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 32'(100 + i)) bad++;
    chk("stream_order_errors", bad, 0);

    // ---- full with simultaneous push and pop ----
    got.delete();
    data_ctr = 32'h10;
    repeat (8) cycle(1'b1, 1'b0);
    chk("full_occupancy", occupancy, 4);
    chk("full_head", out_data, 32'h10);
    cycle(1'b0, 1'b1, 1'b1, 32'h55);
    chk("pushpop_occupancy", occupancy, 4);
    chk("pushpop_no_overflow", overflow_err, 1'b0);
    chk("pushpop_head_advanced", out_data, 32'h11);

    // ---- illegal push while full ----
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_DEAD);
    chk("ovf_set", overflow_err, 1'b1);
    chk("ovf_occupancy", occupancy, 4);
    chk("ovf_head_kept", out_data, 32'h11);
    repeat (2) cycle(1'b0, 1'b0);
    chk("ovf_sticky", overflow_err, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);
    chk("ovf_drain_count", got.size(), 5);
    if (got.size() == 5) chk("ovf_drain_last", got[4], 32'h55);
    chk("dead_never_output", dead_seen, 1'b0);
    chk("ovf_sticky_after_drain", overflow_err, 1'b1);

    // ---- reset mid-burst ----
    repeat (3) cycle(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_reset_outputs("midrst");
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    pipe_valid  = 1'b0;
    clear_pipe();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle(1'b0, 1'b0);
    expect_reset_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
